// File: rtl/lcd_rect_fill_engine.sv
// Rectangle fill engine: turns one (x0,y0,x1,y1,color) descriptor into the
// CASET / PASET / RAMWR command stream plus W*H pixel words on a valid/ready port.
//
// state     | meaning
// IDLE      | waiting for start
// CASET_C   | column-address command word
// CASET_P   | four column parameter words
// PASET_C   | page-address command word
// PASET_P   | four page parameter words
// RAMWR_C   | memory-write command word
// PIXELS    | W*H colour words
module lcd_rect_fill_engine #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 480,
  parameter int COORD_W = 10
) (
  input  logic               AHB_HCLK,
  input  logic               AHB_HRESET,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [15:0]        color,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_is_cmd,
  output logic [15:0]        out_data
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET_C, S_CASET_P, S_PASET_C, S_PASET_P, S_RAMWR_C, S_PIXELS
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0] wm1_q, wm1_d, hm1_q, hm1_d;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [15:0]        color_q, color_d;
  logic [1:0]         pidx_q, pidx_d;
  logic               done_q, done_d, err_q, err_d;
  logic               xfer, desc_bad;

  // Parameter words: start hi, start lo, end hi, end lo of the zero-extended coordinates.
  function automatic logic [15:0] param_word(input logic [1:0] idx,
                                             input logic [COORD_W-1:0] a,
                                             input logic [COORD_W-1:0] b);
    logic [15:0] a16, b16, w;
    a16 = 16'(a);
    b16 = 16'(b);
    case (idx)
      2'd0:    w = {8'h00, a16[15:8]};
      2'd1:    w = {8'h00, a16[7:0]};
      2'd2:    w = {8'h00, b16[15:8]};
      default: w = {8'h00, b16[7:0]};
    endcase
    return w;
  endfunction

  always_comb begin
    out_valid  = (state_q != S_IDLE);
    out_is_cmd = 1'b0;
    out_data   = 16'h0000;
    case (state_q)
      S_CASET_C: begin out_is_cmd = 1'b1; out_data = 16'h002A; end
      S_CASET_P: out_data = param_word(pidx_q, x0_q, x1_q);
      S_PASET_C: begin out_is_cmd = 1'b1; out_data = 16'h002B; end
      S_PASET_P: out_data = param_word(pidx_q, y0_q, y1_q);
      S_RAMWR_C: begin out_is_cmd = 1'b1; out_data = 16'h002C; end
      S_PIXELS:  out_data = color_q;
      default:   ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;
  assign xfer = out_valid && out_ready;
  assign desc_bad = (x0 > x1) || (y0 > y1) || (x1 >= X_LIM) || (y1 >= Y_LIM);

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    wm1_d   = wm1_q;
    hm1_d   = hm1_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    pidx_d  = pidx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (desc_bad) begin
            err_d = 1'b1;
          end else begin
            x0_d    = x0;
            y0_d    = y0;
            x1_d    = x1;
            y1_d    = y1;
            wm1_d   = x1 - x0;
            hm1_d   = y1 - y0;
            color_d = color;
            col_d   = '0;
            row_d   = '0;
            pidx_d  = '0;
            state_d = S_CASET_C;
          end
        end
      end
      S_CASET_C: if (xfer) state_d = S_CASET_P;
      S_CASET_P: begin
        if (xfer) begin
          pidx_d = pidx_q + 2'd1;
          if (pidx_q == 2'd3) state_d = S_PASET_C;
        end
      end
      S_PASET_C: if (xfer) state_d = S_PASET_P;
      S_PASET_P: begin
        if (xfer) begin
          pidx_d = pidx_q + 2'd1;
          if (pidx_q == 2'd3) state_d = S_RAMWR_C;
        end
      end
      S_RAMWR_C: if (xfer) state_d = S_PIXELS;
      S_PIXELS: begin
        if (xfer) begin
          if (col_q == wm1_q) begin
            col_d = '0;
            if (row_q == hm1_q) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort takes priority over a last-pixel handshake on the same cycle: no done.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      col_d   = '0;
      row_d   = '0;
      pidx_d  = '0;
    end
  end

  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESET) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      wm1_q   <= '0;
      hm1_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      pidx_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      wm1_q   <= wm1_d;
      hm1_q   <= hm1_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
      pidx_q  <= pidx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
